branch_predictor: RTL
=====================

# branch_predictor

Parametrised conditional-branch direction predictor for the pipelined RV32I core. Supports static, bimodal, gshare and tournament modes, with configurable table depth and history length. Fetch queries it combinationally every cycle. Execute updates it once per resolved conditional branch. On a misprediction it restores the speculative global history, and it keeps branch/mispredict performance counters.

## Interface
- `predict_s_index`, default 7: table index width; every table holds 2^predict_s_index entries.
- `GHR_BITS`, default 7: global history length; legal range 1..predict_s_index.
- `MODE`, default 3: 0 static not-taken, 1 bimodal, 2 gshare, 3 tournament.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pred_pc`  in  32  fetch PC.
- `pred_is_branch`  in  1  fetched instruction is a conditional branch and fetch is advancing this cycle.
- `pred_taken`  out  1  predicted direction for `pred_pc`; combinational.
- `pred_ghr`  out  GHR_BITS  speculative history snapshot used for this prediction; carried down the pipe.
- `upd_valid`  in  1  a conditional branch resolved this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_ghr`  in  GHR_BITS  `pred_ghr` snapshot that travelled with that branch.
- `upd_taken`  in  1  actual direction.
- `upd_mispredict`  in  1  actual direction differs from the prediction.
- `perf_branches`  out  32  resolved-branch count; saturates at 0xFFFFFFFF.
- `perf_mispredicts`  out  32  mispredict count; saturates at 0xFFFFFFFF.

## Operation
- Index derivation:
  - `li` = `pc[predict_s_index+1:2]`.
  - `gi` = `li` XOR zero-extended GHR.
  - Prediction uses the speculative GHR; update uses `upd_ghr`.
- Tables of 2-bit saturating counters:
  - LOCAL, indexed by `li`.
  - GLOBAL, indexed by `gi`.
  - CHOOSER, indexed by `li`.
  - A counter value of 2 or more means taken (LOCAL/GLOBAL) or "use global" (CHOOSER).
- `pred_taken` by mode:
  - MODE 0: always 0.
  - MODE 1: LOCAL.
  - MODE 2: GLOBAL.
  - MODE 3: GLOBAL if CHOOSER ≥ 2, else LOCAL.
- Table update when `upd_valid` (MODE 0 updates no tables):
  - Each enabled LOCAL/GLOBAL counter moves toward `upd_taken`: +1 saturating at 3 if taken, −1 saturating at 0 if not taken.
  - MODE 3 only: CHOOSER changes only when the LOCAL and GLOBAL directions (read at the update indices before the write) disagree. It increments when GLOBAL was correct and decrements when LOCAL was correct, saturating at both ends.
  - MODE 1 does not update GLOBAL; MODE 2 does not update LOCAL.
- Speculative GHR update, highest priority first:
  1. `upd_valid` && `upd_mispredict`: GHR <= {`upd_ghr`[GHR_BITS-2:0], `upd_taken`}. Any same-cycle `pred_is_branch` shift is discarded; fetch is being redirected.
  2. `pred_is_branch`: GHR <= {GHR[GHR_BITS-2:0], `pred_taken`}.
  3. Otherwise GHR holds.
  - For GHR_BITS = 1, the shifted value is just the new bit.
  - The GHR is maintained in every mode.
- Performance counters:
  - `perf_branches` +1 on each `upd_valid`.
  - `perf_mispredicts` +1 on each `upd_valid` && `upd_mispredict`.
  - Both saturate and never wrap.
- `upd_mispredict` without `upd_valid` is ignored.
- Upper PC bits and `pc[1:0]` are ignored.

## Timing
- Reset (asynchronous assert, effective immediately):
  - All LOCAL/GLOBAL counters = 1 (weakly not-taken); all CHOOSER counters = 1 (weakly local).
  - GHR = 0; perf counters = 0.
  - Hence `pred_taken` = 0 and `pred_ghr` = 0 during and immediately after reset.
- Reset asserted mid-operation discards all learned state; release is synchronous to the next `clk` edge.
- Prediction latency is 0 cycles: `pred_taken` and `pred_ghr` are combinational from `pred_pc` and current state.
- Update latency is 1 cycle: a table write on edge N is visible to a lookup in cycle N+1.
- A same-cycle lookup of the entry being updated returns the pre-update value; no bypass.
- No handshake or backpressure: the predictor accepts one lookup and one update every cycle.

## Test plan
- Reset: hold `rst`=0, drive `pred_pc`=0x40 -> `pred_taken`=0, `pred_ghr`=0, both perf counters 0.
- Bimodal training (MODE 1): two updates at pc 0x100 with taken=1 -> `pred_taken`=1 for 0x100; one further not-taken update -> still 1 (counter 2); another -> 0.
- Saturation/alias (MODE 1, predict_s_index=7): four taken updates at 0x100, then lookup 0x300 -> 1 (same index 0x40); 3 not-taken updates -> 0.
- Gshare history (MODE 2, GHR_BITS=4): three `pred_is_branch` cycles predicting 1,0,1 -> `pred_ghr`=4'b0101. Then a mispredict update with `upd_ghr`=4'b0011, taken=0, in the same cycle as `pred_is_branch` -> GHR=4'b0110.
- Tournament chooser (MODE 3): train a pattern where GLOBAL is correct and LOCAL wrong twice at the same `li` -> CHOOSER reaches 3 and the prediction follows GLOBAL. Updates where both agree leave CHOOSER unchanged.
- Perf saturation: force-preload `perf_mispredicts`=0xFFFFFFFE, apply two mispredict updates -> 0xFFFFFFFF, no wrap; `perf_branches` advances by 2.

Source files
------------

// File: rtl/branch_predictor.sv
// Conditional-branch direction predictor: static, bimodal, gshare or tournament selection over
// 2-bit counter tables, with speculative global history recovery and saturating perf counters.
module branch_predictor #(
    parameter int unsigned predict_s_index = 7,
    parameter int unsigned GHR_BITS        = 7,
    parameter int unsigned MODE            = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pred_pc,
    input  logic                pred_is_branch,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int unsigned IdxW    = predict_s_index;
    localparam int unsigned Entries = 1 << IdxW;

    logic [1:0] loc_q [Entries];
    logic [1:0] loc_d [Entries];
    logic [1:0] glb_q [Entries];
    logic [1:0] glb_d [Entries];
    logic [1:0] cho_q [Entries];
    logic [1:0] cho_d [Entries];

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         perf_br_q, perf_br_d;
    logic [31:0]         perf_mis_q, perf_mis_d;

    logic [IdxW-1:0] p_li, p_gi, p_hist;
    logic [IdxW-1:0] u_li, u_gi, u_hist;
    logic            p_loc_dir, p_glb_dir, p_use_glb;
    logic            u_loc_dir, u_glb_dir;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        end
        return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

    always_comb begin : lookup
        p_hist                 = '0;
        p_hist[GHR_BITS-1:0]   = ghr_q;
        p_li                   = pred_pc[IdxW+1:2];
        p_gi                   = p_li ^ p_hist;
        p_loc_dir              = loc_q[p_li][1];
        p_glb_dir              = glb_q[p_gi][1];
        p_use_glb              = cho_q[p_li][1];
        case (MODE)
            1:       pred_taken = p_loc_dir;
            2:       pred_taken = p_glb_dir;
            3:       pred_taken = p_use_glb ? p_glb_dir : p_loc_dir;
            default: pred_taken = 1'b0;
        endcase
    end

    assign pred_ghr = ghr_q;

    // Directions are sampled before the write so the chooser judges the pre-update tables.
    always_comb begin : train
        loc_d                = loc_q;
        glb_d                = glb_q;
        cho_d                = cho_q;
        u_hist               = '0;
        u_hist[GHR_BITS-1:0] = upd_ghr;
        u_li                 = upd_pc[IdxW+1:2];
        u_gi                 = u_li ^ u_hist;
        u_loc_dir            = loc_q[u_li][1];
        u_glb_dir            = glb_q[u_gi][1];
        if (upd_valid) begin
            if (MODE == 1 || MODE == 3) begin
                loc_d[u_li] = sat_step(loc_q[u_li], upd_taken);
            end
            if (MODE == 2 || MODE == 3) begin
                glb_d[u_gi] = sat_step(glb_q[u_gi], upd_taken);
            end
            if (MODE == 3 && (u_loc_dir != u_glb_dir)) begin
                cho_d[u_li] = sat_step(cho_q[u_li], u_glb_dir == upd_taken);
            end
        end
    end

    // A resolved mispredict rebuilds history from its snapshot and overrides any fetch shift.
    always_comb begin : history
        ghr_d = ghr_q;
        if (upd_valid && upd_mispredict) begin
            ghr_d = GHR_BITS'({upd_ghr, upd_taken});
        end else if (pred_is_branch) begin
            ghr_d = GHR_BITS'({ghr_q, pred_taken});
        end
    end

    always_comb begin : perf
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (upd_valid && (perf_br_q != '1)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (upd_valid && upd_mispredict && (perf_mis_q != '1)) begin
            perf_mis_d = perf_mis_q + 32'd1;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                loc_q[i] <= 2'd1;
                glb_q[i] <= 2'd1;
                cho_q[i] <= 2'd1;
            end
            ghr_q      <= '0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            loc_q      <= loc_d;
            glb_q      <= glb_d;
            cho_q      <= cho_d;
            ghr_q      <= ghr_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IdxW+2], pred_pc[1:0], upd_pc[31:IdxW+2], upd_pc[1:0]};

endmodule
